// File: rtl/hls_tcdm_port_mux.sv
// rtl/hls_tcdm_port_mux.sv - concentrates N_CH HLS memory channels onto MP TCDM ports (c mod MP), RR arbitration, in-order response routing.
// Optional per-port stall counters behind HLS_TCDM_MUX_PERF_EN.
module hls_tcdm_port_mux #(
    parameter int N_CH       = 4,
    parameter int MP         = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [N_CH-1:0]      ch_req_i,
    output logic [N_CH-1:0]      ch_gnt_o,
    input  logic [N_CH*AW-1:0]   ch_add_i,
    input  logic [N_CH-1:0]      ch_wen_i,
    input  logic [N_CH*DW/8-1:0] ch_be_i,
    input  logic [N_CH*DW-1:0]   ch_data_i,
    output logic [N_CH*DW-1:0]   ch_r_data_o,
    output logic [N_CH-1:0]      ch_r_valid_o,
    output logic [MP-1:0]        tcdm_req_o,
    input  logic [MP-1:0]        tcdm_gnt_i,
    output logic [MP*AW-1:0]     tcdm_add_o,
    output logic [MP-1:0]        tcdm_wen_o,
    output logic [MP*DW/8-1:0]   tcdm_be_o,
    output logic [MP*DW-1:0]     tcdm_data_o,
    input  logic [MP*DW-1:0]     tcdm_r_data_i,
    input  logic [MP-1:0]        tcdm_r_valid_i,
    output logic                 err_o
`ifdef HLS_TCDM_MUX_PERF_EN
    ,
    output logic [MP*32-1:0]     perf_stall_o
`endif
);

    localparam int KMAX = (N_CH + MP - 1) / MP;
    localparam int IW   = (KMAX > 1) ? $clog2(KMAX) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int BW   = DW / 8;

    function automatic int rr_member(input int base, input int off, input int k);
        return (base + off >= k) ? base + off - k : base + off;
    endfunction

    logic [MP-1:0] port_gnt;
    logic [MP-1:0] port_rsp;
    logic [MP-1:0] err_set;
    logic [IW-1:0] port_sel  [MP];
    logic [IW-1:0] port_head [MP];

    for (genvar p = 0; p < MP; p++) begin : g_port
        localparam int K = (N_CH - p + MP - 1) / MP;

        logic [IW-1:0] rr_q;
        logic [IW-1:0] sel_k;
        logic          sel_valid;
        logic [AW-1:0] sel_add;
        logic          sel_wen;
        logic [BW-1:0] sel_be;
        logic [DW-1:0] sel_data;
        logic [IW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] wr_q;
        logic [PW-1:0] rd_q;
        logic [CW-1:0] cnt_q;
        logic          empty, full, pop, req, push;

        always_comb begin : p_arb
            int m;
            m         = 0;
            sel_valid = 1'b0;
            sel_k     = '0;
            sel_add   = '0;
            sel_wen   = 1'b0;
            sel_be    = '0;
            sel_data  = '0;
            for (int i = 0; i < K; i++) begin
                m = rr_member(int'(rr_q), i, K);
                if (!sel_valid && ch_req_i[p + m*MP]) begin
                    sel_valid = 1'b1;
                    sel_k     = IW'(m);
                    sel_add   = ch_add_i[(p + m*MP)*AW +: AW];
                    sel_wen   = ch_wen_i[p + m*MP];
                    sel_be    = ch_be_i[(p + m*MP)*BW +: BW];
                    sel_data  = ch_data_i[(p + m*MP)*DW +: DW];
                end
            end
        end

        assign empty = (cnt_q == '0);
        assign full  = (cnt_q == CW'(FIFO_DEPTH));
        assign pop   = tcdm_r_valid_i[p] & ~empty;
        // a response in the same cycle frees a slot, so a full FIFO can still accept
        assign req   = rst_ni & sel_valid & (~full | pop);
        assign push  = req & tcdm_gnt_i[p];

        assign tcdm_req_o[p]            = req;
        assign tcdm_add_o[p*AW +: AW]   = rst_ni ? sel_add  : '0;
        assign tcdm_wen_o[p]            = rst_ni & sel_wen;
        assign tcdm_be_o[p*BW +: BW]    = rst_ni ? sel_be   : '0;
        assign tcdm_data_o[p*DW +: DW]  = rst_ni ? sel_data : '0;

        assign port_gnt[p]  = push;
        assign port_sel[p]  = sel_k;
        assign port_head[p] = mem_q[rd_q];
        assign port_rsp[p]  = rst_ni & pop;
        assign err_set[p]   = tcdm_r_valid_i[p] & empty;

        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_q] <= sel_k;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rr_q  <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else if (clear_i) begin
                rr_q  <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    wr_q <= wr_q + 1'b1;
                    rr_q <= (int'(sel_k) == K - 1) ? '0 : sel_k + 1'b1;
                end
                if (pop) begin
                    rd_q <= rd_q + 1'b1;
                end
                if (push && !pop) begin
                    cnt_q <= cnt_q + 1'b1;
                end else if (pop && !push) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end

`ifdef HLS_TCDM_MUX_PERF_EN
        logic        stall;
        logic [31:0] perf_q;

        always_comb begin
            stall = 1'b0;
            for (int i = 0; i < K; i++) begin
                if (ch_req_i[p + i*MP] && !(push && int'(sel_k) == i)) begin
                    stall = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                perf_q <= '0;
            end else if (clear_i) begin
                perf_q <= '0;
            end else if (stall && perf_q != 32'hFFFF_FFFF) begin
                perf_q <= perf_q + 32'd1;
            end
        end

        assign perf_stall_o[p*32 +: 32] = perf_q;
`endif
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        localparam int P  = c % MP;
        localparam int KI = c / MP;

        assign ch_gnt_o[c]            = port_gnt[P] & (port_sel[P] == IW'(KI));
        assign ch_r_valid_o[c]        = port_rsp[P] & (port_head[P] == IW'(KI));
        assign ch_r_data_o[c*DW +: DW] = ch_r_valid_o[c] ? tcdm_r_data_i[P*DW +: DW] : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (clear_i) begin
            err_o <= 1'b0;
        end else if (|err_set) begin
            err_o <= 1'b1;
        end
    end

endmodule
